// File: rtl/usr_pkg.sv
// Shared definitions for the serial link: frame-state encoding and shift-direction codes.
// Used by both the transmitter and the receiver.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } usr_state_e;

  localparam logic SR_MSB_FIRST = 1'b0;
  localparam logic SR_LSB_FIRST = 1'b1;

  // Wide enough to count up to 16 data bits.
  localparam int unsigned USR_CNT_W = 5;

  function automatic logic even_parity_bad(input logic [15:0] data, input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/usr_rx_shift.sv
// WIDTH-bit receive shift register with selectable direction, enable and load-clear.
// dir=SR_MSB_FIRST fills from bit 0 upward; dir=SR_LSB_FIRST fills from the top downward.
module usr_rx_shift
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_clr,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             din,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_clr) begin
      data_d = '0;
    end else if (shift_en) begin
      if (dir == SR_MSB_FIRST) begin
        data_d = {data_q[WIDTH-2:0], din};
      end else begin
        data_d = {din, data_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/usr_serial_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Delivers the word through a VALID/ACK handshake with sticky error flags.
//
// state  | meaning
// IDLE   | waiting for a start bit (SI != IDLE_LEVEL on a strobe)
// DATA   | shifting in WIDTH data bits
// PARITY | capturing the parity bit
// STOP   | sampling the stop bit and completing the frame
module usr_serial_rx
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             BIT_EN,
  input  logic             SI,
  input  logic             SR,
  input  logic             ACK,
  output logic [WIDTH-1:0] PARALLEL_OUT,
  output logic             VALID,
  output logic             PARITY_ERR,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  output logic             BUSY
);

  localparam logic [USR_CNT_W-1:0] LAST_BIT = USR_CNT_W'(WIDTH - 1);

  usr_state_e           state_q, state_d;
  logic [USR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 par_q, par_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic                 rst_n;
  logic                 shift_clr;
  logic                 shift_en;
  logic                 frame_good;
  logic [WIDTH-1:0]     word;
  logic [15:0]          word_ext;

  // RST and CLR have identical effect on all state, so they share one reset path.
  assign rst_n    = RST & CLR;
  assign word_ext = 16'(word);

  usr_rx_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (CLK),
    .rst_n    (rst_n),
    .load_clr (shift_clr),
    .shift_en (shift_en),
    .dir      (dir_q),
    .din      (SI),
    .data     (word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    par_d      = par_q;
    out_d      = out_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    shift_clr  = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;

    if (BIT_EN) begin
      unique case (state_q)
        IDLE: begin
          if (SI != IDLE_LEVEL) begin
            state_d   = DATA;
            cnt_d     = '0;
            dir_d     = SR;
            shift_clr = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + USR_CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_d   = SI;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (SI != IDLE_LEVEL) begin
            ferr_d = 1'b1;
          end else if (PARITY_EN && even_parity_bad(word_ext, par_q)) begin
            perr_d = 1'b1;
          end else begin
            frame_good = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A good frame landing in the ACK cycle replaces the consumed word instead of clearing VALID.
    if (ACK && valid_q) begin
      valid_d = 1'b0;
    end
    if (frame_good) begin
      if (!valid_q || ACK) begin
        out_d   = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST || !CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= SR_MSB_FIRST;
      par_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      par_q   <= par_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign PARALLEL_OUT = out_q;
  assign VALID        = valid_q;
  assign PARITY_ERR   = perr_q;
  assign FRAME_ERR    = ferr_q;
  assign OVERRUN      = ovr_q;
  assign BUSY         = (state_q != IDLE);

endmodule

// File: tb/tb_usr_serial_rx.sv
// Self-checking bench for usr_serial_rx (WIDTH=4, even parity, idle-high line).
// Expected words are queued as frames are driven and compared when the DUT presents them.
module tb_usr_serial_rx;

  logic       CLK = 1'b0;
  logic       RST, CLR, BIT_EN, SI, SR, ACK;
  logic [3:0] PARALLEL_OUT;
  logic       VALID, PARITY_ERR, FRAME_ERR, OVERRUN, BUSY;

  int n_cmp = 0;
  int n_err = 0;
  bit toggle_en = 1'b0;
  logic [3:0] sb[$];

  always #5 CLK = ~CLK;

  usr_serial_rx #(
    .WIDTH      (4),
    .PARITY_EN  (1'b1),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CLR          (CLR),
    .BIT_EN       (BIT_EN),
    .SI           (SI),
    .SR           (SR),
    .ACK          (ACK),
    .PARALLEL_OUT (PARALLEL_OUT),
    .VALID        (VALID),
    .PARITY_ERR   (PARITY_ERR),
    .FRAME_ERR    (FRAME_ERR),
    .OVERRUN      (OVERRUN),
    .BUSY         (BUSY)
  );

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    SI     = b;
    BIT_EN = 1'b1;
    @(posedge CLK); #1;
    if (toggle_en) begin
      BIT_EN = 1'b0;
      @(posedge CLK); #1;
      BIT_EN = 1'b1;
    end
  endtask

  // Data bits go out d[3] first; sr selects how the receiver reassembles them.
  task automatic send_frame(input logic [3:0] d, input logic sr, input logic bad_par,
                            input logic stop_b, input bit expect_good, input bit ack_stop,
                            input bit flip_sr);
    logic [3:0] old_w;
    SR = sr;
    send_bit(1'b0);
    if (flip_sr) SR = ~sr;
    for (int i = 3; i >= 0; i--) send_bit(d[i]);
    send_bit((^d) ^ bad_par);
    if (ack_stop) begin
      old_w = (sb.size() > 0) ? sb.pop_front() : 4'bx;
      chk("ack_old_word", PARALLEL_OUT, old_w);
      ACK = 1'b1;
    end
    if (expect_good) sb.push_back(sr ? rev4(d) : d);
    send_bit(stop_b);
    ACK = 1'b0;
    SR  = sr;
  endtask

  task automatic take_word(input string tag);
    int n;
    logic [3:0] exp_w;
    n = 0;
    while (!VALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, "_valid"}, VALID, 1);
    exp_w = (sb.size() > 0) ? sb.pop_front() : 4'bx;
    chk({tag, "_word"}, PARALLEL_OUT, exp_w);
    ACK = 1'b1;
    @(posedge CLK); #1;
    ACK = 1'b0;
    chk({tag, "_ack_clr"}, VALID, 0);
  endtask

  task automatic pulse_clr();
    CLR = 1'b0;
    @(posedge CLK); #1;
    CLR = 1'b1;
  endtask

  initial begin
    RST = 1'b0; CLR = 1'b1; BIT_EN = 1'b1; SI = 1'b1; SR = 1'b0; ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out",   PARALLEL_OUT, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_perr",  PARITY_ERR, 0);
    chk("rst_ferr",  FRAME_ERR, 0);
    chk("rst_ovr",   OVERRUN, 0);
    chk("rst_busy",  BUSY, 0);
    RST = 1'b1;
    send_bit(1'b1);

    // MSB-first word; VALID must be up right after the stop-bit edge.
    send_frame(4'b1010, 1'b0, 1'b0, 1'b1, 1, 0, 0);
    chk("msb_latency_valid", VALID, 1);
    chk("msb_busy_after", BUSY, 0);
    chk("msb_no_perr", PARITY_ERR, 0);
    chk("msb_no_ferr", FRAME_ERR, 0);
    take_word("msb");

    // LSB-first, with SR flipped mid-frame (must be ignored).
    send_frame(4'b1010, 1'b1, 1'b0, 1'b1, 1, 0, 1);
    take_word("lsb");

    send_frame(4'b1010, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    chk("par_err_flag", PARITY_ERR, 1);
    chk("par_err_valid", VALID, 0);
    send_bit(1'b1);
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    send_bit(1'b1);
    chk("frm_err_flag", FRAME_ERR, 1);
    chk("frm_err_valid", VALID, 0);
    chk("par_err_sticky", PARITY_ERR, 1);
    pulse_clr();
    chk("clr_perr", PARITY_ERR, 0);
    chk("clr_ferr", FRAME_ERR, 0);

    // Back-to-back frames without ACK: second word dropped.
    send_frame(4'b1100, 1'b0, 1'b0, 1'b1, 1, 0, 0);
    send_frame(4'b0011, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    chk("ovr_flag", OVERRUN, 1);
    take_word("ovr");
    pulse_clr();
    chk("clr_ovr", OVERRUN, 0);

    // Back-to-back with ACK on the second completion: new word replaces old.
    send_frame(4'b1100, 1'b0, 1'b0, 1'b1, 1, 0, 0);
    send_frame(4'b0011, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    chk("ackcmp_valid", VALID, 1);
    chk("ackcmp_ovr", OVERRUN, 0);
    take_word("ackcmp");

    // Reset after the second data bit abandons the frame.
    SR = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("mid_busy_pre", BUSY, 1);
    RST = 1'b0; SI = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1;
    chk("mid_rst_busy", BUSY, 0);
    repeat (6) send_bit(1'b1);
    chk("mid_rst_novalid", VALID, 0);
    send_frame(4'b0110, 1'b0, 1'b0, 1'b1, 1, 0, 0);
    take_word("post_rst");

    // Half-rate strobing, then build up VALID plus every flag and soft-clear.
    toggle_en = 1'b1;
    send_frame(4'b1001, 1'b0, 1'b0, 1'b1, 1, 0, 0);
    chk("tog_valid", VALID, 1);
    chk("tog_word", PARALLEL_OUT, (sb.size() > 0) ? sb.pop_front() : 4'bx);
    send_frame(4'b0101, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    send_frame(4'b0101, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    send_bit(1'b1);
    send_frame(4'b0110, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    toggle_en = 1'b0;
    chk("tog_keep_word", PARALLEL_OUT, 4'b1001);
    chk("tog_perr", PARITY_ERR, 1);
    chk("tog_ferr", FRAME_ERR, 1);
    chk("tog_ovr", OVERRUN, 1);
    pulse_clr();
    chk("clr_valid", VALID, 0);
    chk("clr_out", PARALLEL_OUT, 0);
    chk("clr_all_perr", PARITY_ERR, 0);
    chk("clr_all_ferr", FRAME_ERR, 0);
    chk("clr_all_ovr", OVERRUN, 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
